// File: rtl/rr_arbiter4.sv
// Purpose : round-robin arbiter sharing one 2-to-4 decoded resource among four requesters.
// Latency : a request seen at an IDLE edge is granted the following cycle; a one-cycle GAP follows every release.
// Backpressure: a grantee keeps the resource while it holds req, up to MAX_HOLD cycles; other requesters wait.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      [3:0] request vector, req[i] held high while requester i wants the resource
//   gnt      [3:0] registered one-hot grant, zero when no grant is active
//   gnt_idx  [1:0] registered index of the current/last grantee (decoder select)
//   gnt_vld  registered grant-active flag
//   timeout  one-cycle pulse after a grant is withdrawn by the hold limit
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             timeout_q, timeout_d;

    // Rotating priority scan: first set request starting at ptr, wrapping mod 4.
    logic [1:0] win_idx;
    logic       win_found;
    logic [1:0] cand;

    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_idx_d = win_idx;
                    gnt_vld_d = 1'b1;
                    cnt_d     = ONE_CNT;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req[gnt_idx_q] || (cnt_q == MAX_CNT)) begin
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + 2'd1;
                    state_d   = ST_GAP;
                    // Only a grantee that still wants the resource was cut off;
                    // a coincident req drop counts as a normal release.
                    timeout_d = req[gnt_idx_q];
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            ST_GAP: begin
                gnt_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                gnt_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Grant is registered too, so it is glitch-free and aligned with gnt_vld.
        gnt_d = gnt_vld_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            gnt_idx_q <= 2'd0;
            gnt_vld_q <= 1'b0;
            gnt_q     <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic       rst8;

    logic [3:0] req4, gnt4;
    logic [1:0] idx4;
    logic       vld4, to4;

    logic [3:0] req8, gnt8;
    logic [1:0] idx8;
    logic       vld8, to8;

    logic [3:0] req3, gnt3;
    logic [1:0] idx3;
    logic       vld3, to3;

    int n_total;
    int n_pass;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_vld(vld4), .timeout(to4)
    );

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst8), .req(req8),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_vld(vld8), .timeout(to8)
    );

    rr_arbiter4 #(.MAX_HOLD(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3),
        .gnt(gnt3), .gnt_idx(idx3), .gnt_vld(vld3), .timeout(to3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        n_total = 0;
        n_pass  = 0;

        // Reset held with all requesters asking
        rst_n = 1'b0;
        rst8  = 1'b0;
        req4  = 4'b1111;
        req8  = 4'b1111;
        req3  = 4'b1111;
        #12;
        chk("rst_gnt4", 8'(gnt4), 8'h0);
        chk("rst_idx4", 8'(idx4), 8'h0);
        chk("rst_vld4", 8'(vld4), 8'h0);
        chk("rst_to4",  8'(to4),  8'h0);
        chk("rst_gnt8", 8'(gnt8), 8'h0);
        chk("rst_vld8", 8'(vld8), 8'h0);
        chk("rst_gnt3", 8'(gnt3), 8'h0);
        req8  = 4'b0000;
        req3  = 4'b0000;
        rst_n = 1'b1;
        rst8  = 1'b1;

        // Saturation, MAX_HOLD=4: 0,1,2,3,0 each 4 cycles, 2 idle cycles between
        for (int g = 0; g < 5; g++) begin
            e = 4'b0001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                step();
                chk("sat_gnt", 8'(gnt4), 8'(e));
                chk("sat_to_busy", 8'(to4), 8'h0);
                if (c == 0) chk("sat_idx", 8'(idx4), 8'(g % 4));
            end
            step();
            chk("sat_gap_gnt", 8'(gnt4), 8'h0);
            chk("sat_gap_vld", 8'(vld4), 8'h0);
            chk("sat_timeout", 8'(to4), 8'h1);
            step();
            chk("sat_idle_gnt", 8'(gnt4), 8'h0);
            chk("sat_idle_to", 8'(to4), 8'h0);
        end
        req4 = 4'b0000;

        // Single requester, MAX_HOLD=8: req=0100 sampled at three edges
        req8 = 4'b0100;
        step();
        chk("single_gnt0", 8'(gnt8), 8'h4);
        chk("single_idx0", 8'(idx8), 8'h2);
        chk("single_vld0", 8'(vld8), 8'h1);
        step();
        chk("single_gnt1", 8'(gnt8), 8'h4);
        step();
        chk("single_gnt2", 8'(gnt8), 8'h4);
        req8 = 4'b0000;
        step();
        chk("single_rel_gnt", 8'(gnt8), 8'h0);
        chk("single_rel_vld", 8'(vld8), 8'h0);
        chk("single_rel_idx", 8'(idx8), 8'h2);
        chk("single_rel_to",  8'(to8),  8'h0);
        step();
        chk("single_idle_to", 8'(to8), 8'h0);

        // Grant to 3, release, then pointer wraps to 0
        req8 = 4'b1000;
        step();
        chk("g3_gnt", 8'(gnt8), 8'h8);
        req8 = 4'b0000;
        step();
        chk("g3_rel", 8'(gnt8), 8'h0);
        step();
        req8 = 4'b1001;
        step();
        chk("wrap_gnt0", 8'(gnt8), 8'h1);
        chk("wrap_idx0", 8'(idx8), 8'h0);
        for (int c = 1; c < 8; c++) begin
            step();
            chk("wrap_hold", 8'(gnt8), 8'h1);
        end
        step();
        chk("wrap_rel_gnt", 8'(gnt8), 8'h0);
        chk("wrap_timeout", 8'(to8), 8'h1);
        step();
        chk("wrap_idle_gnt", 8'(gnt8), 8'h0);
        chk("wrap_idle_to", 8'(to8), 8'h0);
        step();
        chk("wrap_gnt3", 8'(gnt8), 8'h8);
        chk("wrap_idx3", 8'(idx8), 8'h3);

        // Async reset mid-BUSY with grantee 2 at cnt=3
        req8 = 4'b0000;
        step();
        step();
        req8 = 4'b0100;
        step();
        chk("ar_gnt2", 8'(gnt8), 8'h4);
        step();
        step();
        #2;
        rst8 = 1'b0;
        #1;
        chk("ar_gnt", 8'(gnt8), 8'h0);
        chk("ar_vld", 8'(vld8), 8'h0);
        chk("ar_idx", 8'(idx8), 8'h0);
        chk("ar_to",  8'(to8),  8'h0);
        req8 = 4'b0110;
        #1;
        rst8 = 1'b1;
        step();
        chk("ar_next_gnt", 8'(gnt8), 8'h2);
        chk("ar_next_idx", 8'(idx8), 8'h1);
        req8 = 4'b0000;

        // MAX_HOLD=3: req drops at the same edge the hold limit is hit
        req3 = 4'b0001;
        step();
        chk("sim_gnt0", 8'(gnt3), 8'h1);
        step();
        step();
        chk("sim_gnt2", 8'(gnt3), 8'h1);
        req3 = 4'b0000;
        step();
        chk("sim_rel_gnt", 8'(gnt3), 8'h0);
        chk("sim_rel_vld", 8'(vld3), 8'h0);
        chk("sim_rel_to",  8'(to3),  8'h0);
        step();
        chk("sim_idle_to", 8'(to3), 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
